// File: rtl/dmem_responder.sv
// dmem_responder: single-port 32-bit data memory responder with a fixed
// request-to-response latency. It accepts one RV32 load/store at a time,
// performs it after LATENCY cycles and holds the response until the
// initiator takes it. Illegal, misaligned or out-of-range requests are
// answered with rsp_error and leave storage untouched.
module dmem_responder #(
  parameter int DEPTH_WORDS = 1024,
  parameter int LATENCY     = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [31:0] req_addr,
  input  logic        req_write,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_error
);

  localparam int         IDX_W    = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam logic [3:0] LAT_INIT = 4'(LATENCY - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } stateT;

  stateT       stateR;
  logic [3:0]  latCntR;
  logic [31:0] addrR;
  logic [31:0] wdataR;
  logic        writeR;
  logic [2:0]  funct3R;
  logic        reqReadyR;
  logic        rspValidR;
  logic        rspErrorR;
  logic [31:0] rspRdataR;

  // Storage is deliberately not reset: contents survive a reset pulse.
  logic [31:0] memR [DEPTH_WORDS];

  logic [IDX_W-1:0] wordIdxS;
  logic [1:0]       laneS;
  logic [31:0]      memWordS;
  logic             illegalS;
  logic             misalignS;
  logic             outOfRangeS;
  logic             errS;
  logic [3:0]       laneMaskS;
  logic [31:0]      storeDataS;
  logic [7:0]       loadByteS;
  logic [15:0]      loadHalfS;
  logic [31:0]      loadDataS;
  logic             accessS;
  logic             storeEnS;

  // Everything below works on the latched request, never on live req_* pins.
  assign wordIdxS = addrR[IDX_W+1:2];
  assign laneS    = addrR[1:0];
  assign memWordS = memR[wordIdxS];

  // The access happens on the edge that leaves BUSY with the counter at zero.
  assign accessS  = (stateR == BUSY) && (latCntR == 4'd0);
  assign storeEnS = accessS && writeR && !errS;

  // Classify the latched request: illegal width code, misalignment, range.
  always_comb begin
    illegalS  = 1'b0;
    misalignS = 1'b0;
    case (funct3R)
      3'b000: begin
        illegalS  = 1'b0;
        misalignS = 1'b0;
      end
      3'b001: begin
        illegalS  = 1'b0;
        misalignS = addrR[0];
      end
      3'b010: begin
        illegalS  = 1'b0;
        misalignS = addrR[1] | addrR[0];
      end
      3'b100: begin
        illegalS  = writeR;
        misalignS = 1'b0;
      end
      3'b101: begin
        illegalS  = writeR;
        misalignS = addrR[0];
      end
      default: begin
        illegalS  = 1'b1;
        misalignS = 1'b0;
      end
    endcase
    outOfRangeS = ({2'b00, addrR[31:2]} >= 32'(DEPTH_WORDS));
    errS        = illegalS | misalignS | outOfRangeS;
  end

  // Byte-lane enables and lane-replicated store data (little-endian).
  always_comb begin
    laneMaskS  = 4'b0000;
    storeDataS = 32'h0000_0000;
    case (funct3R)
      3'b000: begin
        laneMaskS  = 4'b0001 << laneS;
        storeDataS = {4{wdataR[7:0]}};
      end
      3'b001: begin
        laneMaskS  = addrR[1] ? 4'b1100 : 4'b0011;
        storeDataS = {2{wdataR[15:0]}};
      end
      3'b010: begin
        laneMaskS  = 4'b1111;
        storeDataS = wdataR;
      end
      default: begin
        laneMaskS  = 4'b0000;
        storeDataS = 32'h0000_0000;
      end
    endcase
  end

  // Extract the addressed byte/halfword and sign- or zero-extend it.
  always_comb begin
    loadByteS = memWordS[{laneS, 3'b000} +: 8];
    loadHalfS = addrR[1] ? memWordS[31:16] : memWordS[15:0];
    case (funct3R)
      3'b000:  loadDataS = {{24{loadByteS[7]}}, loadByteS};
      3'b001:  loadDataS = {{16{loadHalfS[15]}}, loadHalfS};
      3'b010:  loadDataS = memWordS;
      3'b100:  loadDataS = {24'h00_0000, loadByteS};
      3'b101:  loadDataS = {16'h0000, loadHalfS};
      default: loadDataS = 32'h0000_0000;
    endcase
  end

  // Masked store into storage on the access edge of an error-free store.
  always_ff @(posedge clk) begin
    if (storeEnS) begin
      for (int i = 0; i < 4; i++) begin
        if (laneMaskS[i]) begin
          memR[wordIdxS][8*i +: 8] <= storeDataS[8*i +: 8];
        end
      end
    end
  end

  // Request/response FSM with latency counter and registered handshake outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stateR    <= IDLE;
      latCntR   <= 4'd0;
      addrR     <= 32'h0000_0000;
      wdataR    <= 32'h0000_0000;
      writeR    <= 1'b0;
      funct3R   <= 3'b000;
      reqReadyR <= 1'b0;
      rspValidR <= 1'b0;
      rspErrorR <= 1'b0;
      rspRdataR <= 32'h0000_0000;
    end else begin
      case (stateR)
        IDLE: begin
          if (req_valid && reqReadyR) begin
            addrR     <= req_addr;
            wdataR    <= req_wdata;
            writeR    <= req_write;
            funct3R   <= req_funct3;
            latCntR   <= LAT_INIT;
            reqReadyR <= 1'b0;
            stateR    <= BUSY;
          end else begin
            reqReadyR <= 1'b1;
          end
        end
        BUSY: begin
          if (latCntR == 4'd0) begin
            stateR    <= RESP;
            rspValidR <= 1'b1;
            rspErrorR <= errS;
            rspRdataR <= (errS || writeR) ? 32'h0000_0000 : loadDataS;
          end else begin
            latCntR <= latCntR - 4'd1;
          end
        end
        RESP: begin
          if (rsp_ready) begin
            stateR    <= IDLE;
            rspValidR <= 1'b0;
            rspErrorR <= 1'b0;
            rspRdataR <= 32'h0000_0000;
            reqReadyR <= 1'b1;
          end else begin
            rspValidR <= 1'b1;
          end
        end
        default: begin
          stateR    <= IDLE;
          latCntR   <= 4'd0;
          reqReadyR <= 1'b0;
          rspValidR <= 1'b0;
          rspErrorR <= 1'b0;
          rspRdataR <= 32'h0000_0000;
        end
      endcase
    end
  end

  assign req_ready = reqReadyR;
  assign rsp_valid = rspValidR;
  assign rsp_rdata = rspRdataR;
  assign rsp_error = rspErrorR;

endmodule

// File: tb/tb_dmem_responder.sv
// Self-checking bench for dmem_responder: directed scenarios plus random
// loads/stores compared against a byte-array reference model.
module tb_dmem_responder;

  localparam int DEPTH = 64;
  localparam int LAT   = 2;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic [31:0] req_addr;
  logic        req_write;
  logic [2:0]  req_funct3;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_error;

  int checks = 0;
  int errors = 0;
  int cycle  = 0;

  // Reference storage: one byte per entry plus a "has been written" flag.
  logic [7:0] refMem [DEPTH*4];
  bit         refDef [DEPTH*4];

  dmem_responder #(.DEPTH_WORDS(DEPTH), .LATENCY(LAT)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
    .req_write(req_write), .req_funct3(req_funct3), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .rsp_error(rsp_error)
  );

  always #5 clk = ~clk;

  // Free-running edge counter for spacing measurements.
  always @(posedge clk) cycle <= cycle + 1;

  task automatic checkEq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Behavioural model of one request: error rules, little-endian bytes, extension.
  task automatic modelReq(input logic w, input logic [2:0] f3, input logic [31:0] a,
                          input logic [31:0] wd, output logic expErr,
                          output logic [31:0] expData, output bit known);
    int size;
    int base;
    bit illegal;
    logic [31:0] v;
    illegal = w ? (f3 > 3'd2) : (f3 == 3'd3 || f3 == 3'd6 || f3 == 3'd7);
    size    = (f3[1:0] == 2'd0) ? 1 : ((f3[1:0] == 2'd1) ? 2 : 4);
    expErr  = illegal || ((a % size) != 0) || ((a / 4) >= DEPTH);
    expData = 32'd0;
    known   = 1'b1;
    if (!expErr) begin
      base = int'(a);
      if (w) begin
        for (int i = 0; i < size; i++) begin
          refMem[base+i] = wd[8*i +: 8];
          refDef[base+i] = 1'b1;
        end
      end else begin
        v = 32'd0;
        for (int i = 0; i < size; i++) begin
          v = v | ({24'd0, refMem[base+i]} << (8*i));
          known = known & refDef[base+i];
        end
        if (!f3[2] && size == 1) v = {{24{v[7]}}, v[7:0]};
        if (!f3[2] && size == 2) v = {{16{v[15]}}, v[15:0]};
        expData = v;
      end
    end
  endtask

  // Drive one request, check latency, hold the response 'hold' cycles, handshake.
  task automatic doReq(input logic w, input logic [2:0] f3, input logic [31:0] a,
                       input logic [31:0] wd, input int hold,
                       output logic [31:0] rd, output logic er);
    int n;
    @(negedge clk);
    req_valid = 1'b1; req_write = w; req_funct3 = f3; req_addr = a; req_wdata = wd;
    rsp_ready = 1'b0;
    n = 0;
    while (req_ready !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    checkEq("acceptWait", {31'd0, (n < 20)}, 32'd1);
    @(posedge clk);
    #1;
    // Garbage on the request pins while busy must not matter.
    req_valid = 1'b1; req_write = 1'($urandom); req_funct3 = 3'($urandom);
    req_addr = $urandom; req_wdata = $urandom;
    n = 0;
    while (rsp_valid !== 1'b1 && n < 40) begin
      @(posedge clk);
      #1;
      n++;
    end
    checkEq("latency", 32'(n), 32'(LAT));
    rd = rsp_rdata;
    er = rsp_error;
    for (int k = 0; k < hold; k++) begin
      @(negedge clk);
      checkEq("holdValid", {31'd0, rsp_valid}, 32'd1);
      checkEq("holdData", rsp_rdata, rd);
      checkEq("holdErr", {31'd0, rsp_error}, {31'd0, er});
      checkEq("holdReady", {31'd0, req_ready}, 32'd0);
    end
    req_valid = 1'b0;
    rsp_ready = 1'b1;
    @(posedge clk);
    #1;
    rsp_ready = 1'b0;
    checkEq("postHsValid", {31'd0, rsp_valid}, 32'd0);
    checkEq("postHsReady", {31'd0, req_ready}, 32'd1);
  endtask

  task automatic txn(input string tag, input logic w, input logic [2:0] f3,
                     input logic [31:0] a, input logic [31:0] wd, input int hold,
                     input bit hasExp, input logic [31:0] expv);
    logic expErr;
    logic [31:0] expData;
    bit known;
    logic [31:0] rd;
    logic er;
    modelReq(w, f3, a, wd, expErr, expData, known);
    doReq(w, f3, a, wd, hold, rd, er);
    checkEq({tag, ".err"}, {31'd0, er}, {31'd0, expErr});
    if (known) checkEq({tag, ".data"}, rd, expData);
    if (hasExp) checkEq({tag, ".fixed"}, rd, expv);
  endtask

  initial begin
    int n;
    int accepts [$];
    logic [31:0] a;
    req_valid = 1'b0; req_write = 1'b0; req_funct3 = 3'd0; req_addr = 32'd0;
    req_wdata = 32'd0; rsp_ready = 1'b0;
    for (int i = 0; i < DEPTH*4; i++) refDef[i] = 1'b0;

    // Reset state
    reset = 1'b0;
    #2;
    checkEq("rstValid", {31'd0, rsp_valid}, 32'd0);
    checkEq("rstRdata", rsp_rdata, 32'd0);
    checkEq("rstErr", {31'd0, rsp_error}, 32'd0);
    checkEq("rstReady", {31'd0, req_ready}, 32'd0);
    repeat (3) @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    checkEq("readyAfterRst", {31'd0, req_ready}, 32'd1);

    // Directed functional scenarios
    txn("sw10", 1'b1, 3'b010, 32'h10, 32'h1234_5678, 0, 1'b1, 32'h0);
    txn("lw10", 1'b0, 3'b010, 32'h10, 32'h0, 0, 1'b1, 32'h1234_5678);
    txn("sb13", 1'b1, 3'b000, 32'h13, 32'hAAAA_AA80, 0, 1'b1, 32'h0);
    txn("lb13", 1'b0, 3'b000, 32'h13, 32'h0, 0, 1'b1, 32'hFFFF_FF80);
    txn("lbu13", 1'b0, 3'b100, 32'h13, 32'h0, 0, 1'b1, 32'h0000_0080);
    txn("lw10b", 1'b0, 3'b010, 32'h10, 32'h0, 0, 1'b1, 32'h8034_5678);
    txn("lh11", 1'b0, 3'b001, 32'h11, 32'h0, 0, 1'b1, 32'h0);
    txn("swOob", 1'b1, 3'b010, 32'(4*DEPTH), 32'hCAFE_F00D, 0, 1'b1, 32'h0);
    txn("lw10c", 1'b0, 3'b010, 32'h10, 32'h0, 0, 1'b1, 32'h8034_5678);
    txn("lhu12", 1'b0, 3'b101, 32'h12, 32'h0, 0, 1'b1, 32'h0000_8034);
    txn("lw10hold", 1'b0, 3'b010, 32'h10, 32'h0, 5, 1'b1, 32'h8034_5678);

    // Reset in BUSY drops a pending store
    txn("sw20", 1'b1, 3'b010, 32'h20, 32'h1111_1111, 0, 1'b0, 32'h0);
    @(negedge clk);
    req_valid = 1'b1; req_write = 1'b1; req_funct3 = 3'b010;
    req_addr = 32'h20; req_wdata = 32'hDEAD_BEEF;
    @(posedge clk);
    #3;
    reset = 1'b0;
    req_valid = 1'b0;
    #1;
    checkEq("busyRstValid", {31'd0, rsp_valid}, 32'd0);
    checkEq("busyRstReady", {31'd0, req_ready}, 32'd0);
    checkEq("busyRstRdata", rsp_rdata, 32'd0);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    checkEq("busyRstReady2", {31'd0, req_ready}, 32'd1);
    txn("lw20", 1'b0, 3'b010, 32'h20, 32'h0, 0, 1'b1, 32'h1111_1111);

    // Reset in RESP clears the pending response asynchronously
    @(negedge clk);
    req_valid = 1'b1; req_write = 1'b0; req_funct3 = 3'b010; req_addr = 32'h10;
    rsp_ready = 1'b0;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    n = 0;
    while (rsp_valid !== 1'b1 && n < 40) begin
      @(posedge clk);
      #1;
      n++;
    end
    checkEq("respSeen", {31'd0, rsp_valid}, 32'd1);
    checkEq("respData", rsp_rdata, 32'h8034_5678);
    #2;
    reset = 1'b0;
    #1;
    checkEq("respRstValid", {31'd0, rsp_valid}, 32'd0);
    checkEq("respRstRdata", rsp_rdata, 32'd0);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    checkEq("respRstReady", {31'd0, req_ready}, 32'd1);
    checkEq("respRstGone", {31'd0, rsp_valid}, 32'd0);

    // Random traffic against the reference model
    for (int t = 0; t < 80; t++) begin
      a = (32'($urandom_range(0, DEPTH + 3)) << 2) | 32'($urandom_range(0, 3));
      txn("rnd", 1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), a, $urandom,
          int'($urandom_range(0, 3)), 1'b0, 32'h0);
    end

    // Back-to-back requests: accept spacing with rsp_ready held high
    @(negedge clk);
    req_valid = 1'b1; req_write = 1'b0; req_funct3 = 3'b010; req_addr = 32'h10;
    rsp_ready = 1'b1;
    n = 0;
    while (accepts.size() < 4 && n < 60) begin
      if (req_ready === 1'b1) accepts.push_back(cycle);
      @(negedge clk);
      n++;
    end
    req_valid = 1'b0;
    checkEq("b2bCount", 32'(accepts.size()), 32'd4);
    for (int i = 1; i < accepts.size(); i++) begin
      checkEq("b2bSpacing", 32'(accepts[i] - accepts[i-1]), 32'(LAT + 2));
    end
    repeat (LAT + 3) @(negedge clk);
    rsp_ready = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/dmem_responder.md
DMEM_RESPONDER -- requirements
Module: dmem_responder

Interface
REQ-001: Parameter DEPTH_WORDS, default 1024, sets the number of 32-bit storage words.
REQ-002: Parameter LATENCY, default 2, sets the cycles from request accept to response valid; legal range 1..15.
REQ-003: The block SHALL have a single clock, clk; reset is asynchronous and active-low, port name reset.
REQ-004: clk  input  1  rising-edge clock.
REQ-005: reset  input  1  asynchronous active-low reset.
REQ-006: req_valid  input  1  initiator presents a request.
REQ-007: req_ready  output  1  responder can accept a request.
REQ-008: req_addr  input  32  byte address.
REQ-009: req_write  input  1  1 = store, 0 = load.
REQ-010: req_funct3  input  3  RV32 width code: 000 b, 001 h, 010 w, 100 bu, 101 hu.
REQ-011: req_wdata  input  32  store data, right-aligned.
REQ-012: rsp_valid  output  1  response is available.
REQ-013: rsp_ready  input  1  initiator accepts the response.
REQ-014: rsp_rdata  output  32  load result, already extended.
REQ-015: rsp_error  output  1  request was rejected.

Function
REQ-016: The FSM SHALL have three states: IDLE, BUSY and RESP.
REQ-017: req_ready SHALL be 1 only in IDLE.
REQ-018: A request is accepted on a rising edge with req_valid=1 and req_ready=1; addr, write, funct3 and wdata SHALL be latched and the FSM SHALL go to BUSY with the latency counter = LATENCY-1.
REQ-019: In BUSY, a counter value of 0 SHALL perform the access and move to RESP at that edge; otherwise the counter SHALL decrement.
REQ-020: rsp_valid SHALL be 1 exactly in RESP, first visible after edge N+LATENCY when acceptance is at edge N.
REQ-021: rsp_rdata and rsp_error SHALL hold stable while rsp_valid=1 and rsp_ready=0.
REQ-022: A response handshake (rsp_valid=1 and rsp_ready=1 at an edge) SHALL return the FSM to IDLE; the earliest next accept is the following edge.
REQ-023: Inputs on the req_* ports SHALL be ignored outside the accepting edge; changing them during BUSY or RESP SHALL have no effect.
REQ-024: Storage SHALL be little-endian; word index = addr[31:2] and byte lane = addr[1:0].
REQ-025: A store SHALL write only the selected lanes: sb writes 1 lane, sh writes lanes {addr[1],0}+0..1, sw writes all 4.
REQ-026: A store SHALL complete on the BUSY-to-RESP edge and SHALL return rsp_rdata=0.
REQ-027: A load SHALL extract the addressed byte/halfword and extend it: sign-extend for b and h, zero-extend for bu and hu; w is passed unchanged.
REQ-028: The request SHALL be an error if it is misaligned (h/hu with addr[0]=1, w with addr[1:0]!=0) or addr[31:2] >= DEPTH_WORDS.
REQ-029: The request SHALL also be an error for an illegal funct3: a store funct3 outside {000,001,010}, or a load funct3 in {011,110,111}.
REQ-030: An error SHALL give rsp_error=1 and rsp_rdata=0, with no storage modified and the latency unchanged.
REQ-031: A load from a word not written since power-up returns an undefined value; the bench SHALL NOT check it.

Reset
REQ-032: reset=0 SHALL force IDLE, counter=0, rsp_valid=0, rsp_rdata=0 and rsp_error=0 immediately, without waiting for clk.
REQ-033: req_ready SHALL be 0 while reset=0 and SHALL be 1 from the first cycle after reset rises.
REQ-034: Reset in BUSY SHALL drop the request; a store not yet performed SHALL NOT modify storage.
REQ-035: Reset in RESP SHALL discard the pending response.
REQ-036: Storage contents SHALL NOT be cleared by reset.

Verification
REQ-037: With LATENCY=2: sw 0x12345678 to 0x10, handshake -> rsp_valid high 2 edges after accept with rsp_error=0; then lw 0x10 -> rsp_rdata=0x12345678.
REQ-038: From that state: sb 0x80 to 0x13, then lb 0x13 -> 0xFFFFFF80, lbu 0x13 -> 0x00000080, lw 0x10 -> 0x80345678.
REQ-039: lh 0x11 -> rsp_error=1, rdata=0; sw to byte address 4*DEPTH_WORDS -> rsp_error=1, and a following lw 0x10 is unchanged.
REQ-040: Load with rsp_ready held 0 for 5 cycles -> rsp_valid, rdata and error stay stable and req_ready=0 throughout; IDLE follows the handshake edge.
REQ-041: Assert reset=0 mid-BUSY of sw 0xDEADBEEF to 0x20, whose word holds 0x11111111 -> outputs cleared asynchronously; after reset, lw 0x20 -> 0x11111111.
REQ-042: Back-to-back requests with req_valid held 1 -> accepts spaced exactly LATENCY+2 edges apart when rsp_ready=1.
